// File: rtl/proc_pkg.sv
// proc_pkg: shared types and constants for the instruction-fetch stage.
//   fetch_state_t   - fetch FSM states (IDLE, REQ, HOLD, ERR)
//   NOP_INSTR       - instruction register reset value
//   ROM_BASE_ADDR   - reset value of the fetch address (matches the PC reset value)
//   WORD_ALIGN_MASK - clears the byte-offset bits of a PC to form a word address
package proc_pkg;

   typedef enum logic [1:0] {IDLE, REQ, HOLD, ERR} fetch_state_t;

   localparam logic [31:0] NOP_INSTR       = 32'h0000_0000;
   localparam logic [31:0] ROM_BASE_ADDR   = 32'h0006_0000;
   localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/instr_fetch.sv
// instr_fetch: fetches one 32-bit word per PC from instruction ROM over a req/ack
// handshake and holds it in an instruction register for decode.
// Optional feature: define FETCH_TIMEOUT_EN to enable the ROM ack timeout (ERR state).
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   en         in   fetch enable
//   pc_in      in   current PC
//   pc_inc     out  one-cycle pulse requesting PC += 4
//   flush      in   redirect pulse, discards current/in-flight instruction
//   mem_req    out  ROM read request
//   mem_addr   out  ROM word address
//   mem_ack    in   ROM data valid
//   mem_rdata  in   ROM read data
//   ir         out  instruction register
//   ir_pc      out  address ir was fetched from
//   ir_valid   out  ir holds an unconsumed instruction
//   ir_ready   in   decode accepts ir
//   fetch_err  out  sticky ROM timeout flag
module instr_fetch
   import proc_pkg::*;
#(
   parameter logic [31:0] ROM_BASE = ROM_BASE_ADDR,
   parameter logic [31:0] NOP      = NOP_INSTR
`ifdef FETCH_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT  = 16
`endif
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [31:0] pc_in,
   output logic        pc_inc,
   input  logic        flush,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [31:0] ir,
   output logic [31:0] ir_pc,
   output logic        ir_valid,
   input  logic        ir_ready,
   output logic        fetch_err
);

   fetch_state_t state;
   logic         drop;
   logic         expired;
   logic [31:0]  pc_word;

   assign pc_word = pc_in & WORD_ALIGN_MASK;
   assign mem_req = state == REQ;
   // A completing fetch is kept only if no redirect hit it, either earlier (drop) or now (flush).
   assign pc_inc  = mem_req & mem_ack & ~drop & ~flush;

`ifdef FETCH_TIMEOUT_EN
   logic [15:0] cnt;

   // Counts consecutive un-acked REQ cycles; zero outside REQ so every REQ entry starts fresh.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt <= '0;
      else cnt <= (mem_req && !mem_ack) ? cnt + 16'd1 : 16'd0;
   end

   assign expired   = mem_req & ~mem_ack & (cnt == 16'(TIMEOUT - 1));
   // ERR is only left by reset, so the state itself is the sticky flag.
   assign fetch_err = state == ERR;
`else
   assign expired   = 1'b0;
   assign fetch_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         mem_addr <= ROM_BASE;
         ir       <= NOP;
         ir_pc    <= ROM_BASE;
         ir_valid <= 1'b0;
         drop     <= 1'b0;
      end else begin
         case (state)
            IDLE:
               if (en) begin
                  mem_addr <= pc_word;
                  state    <= REQ;
               end
            REQ:
               if (mem_ack) begin
                  if (pc_inc) begin
                     ir       <= mem_rdata;
                     ir_pc    <= mem_addr;
                     ir_valid <= 1'b1;
                     state    <= HOLD;
                  end else begin
                     // Stale data: re-issue from the redirected PC.
                     drop     <= 1'b0;
                     mem_addr <= pc_word;
                  end
               end else if (expired) state <= ERR;
               else if (flush) drop <= 1'b1;
            HOLD:
               if (flush || ir_ready) begin
                  ir_valid <= 1'b0;
                  mem_addr <= pc_word;
                  state    <= en ? REQ : IDLE;
               end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: self-checking bench for instr_fetch. The bench acts as PC register,
// ROM and decode; a stream model tracks which address decode must see next.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst, en, flush, ir_ready, mem_ack;
   logic        pc_inc, mem_req, ir_valid, fetch_err;
   logic [31:0] pc_in, mem_addr, mem_rdata, ir, ir_pc;

   int          checks = 0;
   int          errors = 0;
   int          inc_cnt = 0;
   int          consumed = 0;
   int          c0;
   int          lat = 0;
   int          waited = 0;
   logic [31:0] pc_reg, exp_pc, prev_addr;
   logic        prev_pending = 1'b0;
   logic        last_inc = 1'b0;

   always #5 clk = ~clk;

   instr_fetch dut (
      .clk(clk), .rst(rst), .en(en), .pc_in(pc_in), .pc_inc(pc_inc), .flush(flush),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready), .fetch_err(fetch_err)
   );

   function automatic logic [31:0] rom(input logic [31:0] a);
      return a == 32'h0006_0000 ? 32'hDEAD_BEEF : (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: drive at negedge, check and advance the model, then let the edge happen.
   task automatic cycle(input logic e, input logic f, input logic rdy, input logic ack,
                        input logic [31:0] tgt, input logic [1:0] junk);
      @(negedge clk);
      en        = e;
      flush     = f;
      ir_ready  = rdy;
      mem_ack   = ack & mem_req;
      mem_rdata = rom(mem_addr);
      pc_in     = (f ? tgt : pc_reg) | {30'd0, junk};
      #1;
      chk("addr_align", {30'd0, mem_addr[1:0]}, 32'd0);
      if (prev_pending && !fetch_err) begin
         chk("req_held", {31'd0, mem_req}, 32'd1);
         chk("addr_held", mem_addr, prev_addr);
      end
      if (!mem_req) chk("inc_without_req", {31'd0, pc_inc}, 32'd0);
      if (ir_valid && rdy && !f) begin
         chk("ir_pc", ir_pc, exp_pc);
         chk("ir", ir, rom(exp_pc));
         exp_pc += 32'd4;
         consumed++;
      end
      if (f) exp_pc = tgt;
      last_inc     = pc_inc;
      inc_cnt     += int'(pc_inc);
      prev_pending = mem_req && !mem_ack;
      prev_addr    = mem_addr;
      @(posedge clk);
      pc_reg = f ? tgt : last_inc ? pc_reg + 32'd4 : pc_reg;
   endtask

   task automatic reset_dut();
      @(negedge clk);
      en    = 1'b0;
      flush = 1'b0;
      pc_in = 32'h0006_0000;
      #2 rst = 1'b0;
      #1;
      chk("rst_req", {31'd0, mem_req}, 32'd0);
      chk("rst_addr", mem_addr, 32'h0006_0000);
      chk("rst_ir", ir, 32'd0);
      chk("rst_ir_pc", ir_pc, 32'h0006_0000);
      chk("rst_valid", {31'd0, ir_valid}, 32'd0);
      chk("rst_inc", {31'd0, pc_inc}, 32'd0);
      chk("rst_err", {31'd0, fetch_err}, 32'd0);
      @(negedge clk);
      rst          = 1'b1;
      pc_reg       = 32'h0006_0000;
      exp_pc       = pc_reg;
      prev_pending = 1'b0;
      inc_cnt      = 0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; flush = 1'b0; ir_ready = 1'b0; mem_ack = 1'b0;
      mem_rdata = '0; pc_in = 32'h0006_0000;
      reset_dut();

      // Single fetch, ack two cycles after the request
      cycle(1, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 1, 0, 0);
      chk("single_inc", {31'd0, last_inc}, 32'd1);
      #1;
      chk("single_ir", ir, 32'hDEAD_BEEF);
      chk("single_ir_pc", ir_pc, 32'h0006_0000);
      chk("single_valid", {31'd0, ir_valid}, 32'd1);
      chk("single_inc_cnt", inc_cnt, 1);

      // Decode stall in HOLD
      repeat (5) begin
         cycle(1, 0, 0, 1, 0, 0);
         #1;
         chk("stall_ir", ir, 32'hDEAD_BEEF);
         chk("stall_req", {31'd0, mem_req}, 32'd0);
      end
      chk("stall_inc_cnt", inc_cnt, 1);
      cycle(1, 0, 1, 0, 0, 0);

      // Back-to-back with same-cycle ack: one instruction every two cycles
      c0 = consumed;
      repeat (6) cycle(1, 0, 1, 1, 0, 0);
      chk("b2b_rate", consumed - c0, 3);

      // Flush while the request is outstanding
      cycle(1, 1, 0, 0, 32'h0006_0100, 0);
      cycle(1, 0, 0, 1, 0, 0);
      chk("flush_drop_inc", {31'd0, last_inc}, 32'd0);
      #1;
      chk("flush_drop_valid", {31'd0, ir_valid}, 32'd0);
      chk("flush_new_addr", mem_addr, 32'h0006_0100);
      cycle(1, 0, 0, 1, 0, 0);
      chk("flush_refetch_inc", {31'd0, last_inc}, 32'd1);
      c0 = consumed;
      cycle(1, 0, 1, 0, 0, 0);
      chk("flush_consumed", consumed - c0, 1);

      // Reset asserted while a request is pending
      cycle(1, 0, 0, 0, 0, 0);
      reset_dut();

`ifdef FETCH_TIMEOUT_EN
      cycle(1, 0, 0, 0, 0, 0);
      repeat (15) cycle(1, 0, 0, 0, 0, 0);
      #1;
      chk("to_not_yet", {31'd0, fetch_err}, 32'd0);
      chk("to_req_still", {31'd0, mem_req}, 32'd1);
      cycle(1, 0, 0, 0, 0, 0);
      #1;
      chk("to_err", {31'd0, fetch_err}, 32'd1);
      chk("to_req_off", {31'd0, mem_req}, 32'd0);
      repeat (3) cycle(1, 1, 1, 1, 32'h0006_0200, 0);
      #1;
      chk("to_sticky", {31'd0, fetch_err}, 32'd1);
      chk("to_sticky_req", {31'd0, mem_req}, 32'd0);
`else
      cycle(1, 0, 0, 0, 0, 0);
      repeat (20) cycle(1, 0, 0, 0, 0, 0);
      #1;
      chk("wait_no_err", {31'd0, fetch_err}, 32'd0);
      chk("wait_req", {31'd0, mem_req}, 32'd1);
`endif
      reset_dut();

      // Randomized traffic against the stream model
      c0 = consumed;
      repeat (1500) begin
         #1;
         cycle(($urandom_range(0, 15) != 0), ($urandom_range(0, 9) == 0),
               ($urandom_range(0, 2) != 0), (waited >= lat),
               32'h0006_0000 + 32'($urandom_range(0, 1023)) * 32'd4,
               2'($urandom_range(0, 3)));
         if (mem_ack) begin
            waited = 0;
            lat    = $urandom_range(0, 4);
         end else if (prev_pending) waited++;
      end
      chk("random_progress", {31'd0, (consumed - c0) > 100}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
